// File: rtl/angle_buf_reader_if.sv
// Output stream of the angle ring-buffer reader: one angle sample per handshake,
// tagged with its wrapped phase difference and ring index.
interface angle_buf_reader_if #(
  parameter int ANG_W = 13,
  parameter int IDX_W = 8
);
  logic             out_valid;
  logic             out_ready;
  logic [ANG_W-1:0] ang_out;
  logic [ANG_W-1:0] ang_diff;
  logic             out_first;
  logic [IDX_W-1:0] out_idx;

  modport master (
    output out_valid, ang_out, ang_diff, out_first, out_idx,
    input  out_ready
  );

  modport slave (
    input  out_valid, ang_out, ang_diff, out_first, out_idx,
    output out_ready
  );
endinterface

// File: rtl/angle_buf_reader.sv
// Read side of the angle ring buffer: tracks occupancy from writer pulses and
// streams entries oldest-first with a wrapped phase difference to the previous sample.
module angle_buf_reader #(
  parameter  int DEPTH = 256,
  parameter  int ANG_W = 13,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               buf_valid,
  input  logic [PTR_W-1:0]   write_ptr,
  input  logic [ANG_W-1:0]   angle_buf [DEPTH],
  input  logic               flush,
  angle_buf_reader_if.master stream,
  output logic [PTR_W:0]     occupancy,
  output logic               ovf,
  output logic [7:0]         drop_cnt
);

  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   occ_reg;
  logic             out_valid_reg;
  logic [ANG_W-1:0] ang_out_reg;
  logic [ANG_W-1:0] ang_diff_reg;
  logic             out_first_reg;
  logic [PTR_W-1:0] out_idx_reg;
  logic [ANG_W-1:0] prev_ang_reg;
  logic             first_pend_reg;
  logic             ovf_reg;
  logic [7:0]       drop_cnt_reg;

  logic             ring_full;
  logic             overflow_case;
  logic             load;
  logic [ANG_W-1:0] cur_ang;
  logic [PTR_W:0]   occ_next;

  assign ring_full     = (occ_reg == (PTR_W+1)'(DEPTH));
  // A write into a full ring has already clobbered the entry at rd_ptr, so that
  // entry is skipped rather than emitted.
  assign overflow_case = buf_valid && ring_full;
  assign load          = (occ_reg != '0) && (!out_valid_reg || stream.out_ready)
                         && !overflow_case && !flush;
  assign cur_ang       = angle_buf[rd_ptr_reg];
  assign occ_next      = occ_reg + {{PTR_W{1'b0}}, buf_valid} - {{PTR_W{1'b0}}, load};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg     <= '0;
      occ_reg        <= '0;
      out_valid_reg  <= 1'b0;
      ang_out_reg    <= '0;
      ang_diff_reg   <= '0;
      out_first_reg  <= 1'b0;
      out_idx_reg    <= '0;
      prev_ang_reg   <= '0;
      first_pend_reg <= 1'b1;
      ovf_reg        <= 1'b0;
      drop_cnt_reg   <= '0;
    end else if (flush) begin
      // Resynchronise to the writer; anything it writes this cycle is discarded.
      rd_ptr_reg     <= write_ptr;
      occ_reg        <= '0;
      out_valid_reg  <= 1'b0;
      first_pend_reg <= 1'b1;
      ovf_reg        <= 1'b0;
      drop_cnt_reg   <= '0;
    end else begin
      if (overflow_case) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        ovf_reg    <= 1'b1;
        if (drop_cnt_reg != 8'hFF)
          drop_cnt_reg <= drop_cnt_reg + 8'd1;
      end else begin
        occ_reg <= occ_next;
      end

      if (load) begin
        out_valid_reg  <= 1'b1;
        ang_out_reg    <= cur_ang;
        ang_diff_reg   <= first_pend_reg ? '0 : (cur_ang - prev_ang_reg);
        out_first_reg  <= first_pend_reg;
        out_idx_reg    <= rd_ptr_reg;
        prev_ang_reg   <= cur_ang;
        rd_ptr_reg     <= rd_ptr_reg + PTR_W'(1);
        first_pend_reg <= 1'b0;
      end else if (stream.out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign stream.out_valid = out_valid_reg;
  assign stream.ang_out   = ang_out_reg;
  assign stream.ang_diff  = ang_diff_reg;
  assign stream.out_first = out_first_reg;
  assign stream.out_idx   = out_idx_reg;
  assign occupancy        = occ_reg;
  assign ovf              = ovf_reg;
  assign drop_cnt         = drop_cnt_reg;

endmodule

// File: tb/tb_angle_buf_reader.sv
// Directed bench for angle_buf_reader: the bench plays the ring-buffer writer
// and checks each emitted sample against hand-computed values.
module tb_angle_buf_reader;

  logic        clk;
  logic        rst;
  logic        buf_valid;
  logic [7:0]  write_ptr;
  logic [12:0] angle_buf [256];
  logic        flush;
  logic [8:0]  occupancy;
  logic        ovf;
  logic [7:0]  drop_cnt;

  int checks;
  int errors;

  angle_buf_reader_if #(.ANG_W(13), .IDX_W(8)) s ();

  angle_buf_reader #(.DEPTH(256), .ANG_W(13)) dut (
    .clk       (clk),
    .rst       (rst),
    .buf_valid (buf_valid),
    .write_ptr (write_ptr),
    .angle_buf (angle_buf),
    .flush     (flush),
    .stream    (s),
    .occupancy (occupancy),
    .ovf       (ovf),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Writer model: store the angle, advance write_ptr, pulse buf_valid for one edge.
  task automatic push(input logic [12:0] a);
    angle_buf[write_ptr] = a;
    write_ptr = write_ptr + 8'd1;
    buf_valid = 1'b1;
    step();
    buf_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    buf_valid = 1'b0;
    flush = 1'b0;
    s.out_ready = 1'b0;
    write_ptr = 8'd0;
    for (int i = 0; i < 256; i++) angle_buf[i] = 13'd0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (s.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", s.out_valid); end
    checks++; if (occupancy !== 9'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", occupancy); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", ovf); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
    checks++; if (s.ang_out !== 13'd0 || s.out_idx !== 8'd0 || s.ang_diff !== 13'd0 || s.out_first !== 1'b0)
      begin errors++; $display("FAIL reset_fields got ang=%h idx=%0d diff=%h first=%0b want 0", s.ang_out, s.out_idx, s.ang_diff, s.out_first); end
  endtask

  task automatic test_single_write();
    do_reset();
    s.out_ready = 1'b1;
    repeat (3) step();
    push(13'h0100);
    checks++; if (occupancy !== 9'd1 || s.out_valid !== 1'b0)
      begin errors++; $display("FAIL single_n1 got occ=%0d valid=%0b want occ=1 valid=0", occupancy, s.out_valid); end
    step();
    checks++; if (s.out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", s.out_valid); end
    checks++; if (s.ang_out !== 13'h0100) begin errors++; $display("FAIL single_ang got %h want 0100", s.ang_out); end
    checks++; if (s.out_idx !== 8'd0 || s.out_first !== 1'b1 || s.ang_diff !== 13'd0)
      begin errors++; $display("FAIL single_tags got idx=%0d first=%0b diff=%h want 0/1/0", s.out_idx, s.out_first, s.ang_diff); end
    checks++; if (occupancy !== 9'd0) begin errors++; $display("FAIL single_occ got %0d want 0", occupancy); end
    step();
    checks++; if (s.out_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %0b want 0", s.out_valid); end
  endtask

  task automatic test_phase_wrap();
    do_reset();
    s.out_ready = 1'b1;
    push(13'h0FF0);
    push(13'h1010);
    checks++; if (s.ang_out !== 13'h0FF0 || s.out_first !== 1'b1)
      begin errors++; $display("FAIL wrap_s0 got ang=%h first=%0b want 0ff0/1", s.ang_out, s.out_first); end
    step();
    checks++; if (s.ang_out !== 13'h1010 || s.ang_diff !== 13'h0020 || s.out_first !== 1'b0)
      begin errors++; $display("FAIL wrap_s1 got ang=%h diff=%h first=%0b want 1010/0020/0", s.ang_out, s.ang_diff, s.out_first); end
    push(13'h1FF0);
    push(13'h0010);
    checks++; if (s.ang_out !== 13'h1FF0 || s.ang_diff !== 13'h0FE0)
      begin errors++; $display("FAIL wrap_s2 got ang=%h diff=%h want 1ff0/0fe0", s.ang_out, s.ang_diff); end
    step();
    checks++; if (s.ang_out !== 13'h0010 || s.ang_diff !== 13'h0020 || s.out_idx !== 8'd3)
      begin errors++; $display("FAIL wrap_s3 got ang=%h diff=%h idx=%0d want 0010/0020/3", s.ang_out, s.ang_diff, s.out_idx); end
  endtask

  task automatic test_backpressure();
    do_reset();
    push(13'h0010);
    push(13'h0020);
    push(13'h0030);
    push(13'h0040);
    for (int i = 0; i < 10; i++) begin
      checks++; if (s.out_valid !== 1'b1 || s.ang_out !== 13'h0010 || s.out_idx !== 8'd0 || occupancy !== 9'd3)
        begin errors++; $display("FAIL stall_%0d got valid=%0b ang=%h idx=%0d occ=%0d want 1/0010/0/3", i, s.out_valid, s.ang_out, s.out_idx, occupancy); end
      step();
    end
    s.out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      step();
      checks++; if (s.out_valid !== 1'b1 || s.out_idx !== 8'(k) || s.ang_out !== 13'(16 * (k + 1)) || s.ang_diff !== 13'h0010)
        begin errors++; $display("FAIL release_%0d got valid=%0b idx=%0d ang=%h diff=%h want 1/%0d/%h/0010", k, s.out_valid, s.out_idx, s.ang_out, s.ang_diff, k, 16 * (k + 1)); end
    end
    step();
    checks++; if (s.out_valid !== 1'b0 || occupancy !== 9'd0)
      begin errors++; $display("FAIL release_end got valid=%0b occ=%0d want 0/0", s.out_valid, occupancy); end
  endtask

  task automatic test_overflow();
    do_reset();
    push(13'h0100);
    step();
    checks++; if (s.out_valid !== 1'b1 || occupancy !== 9'd0)
      begin errors++; $display("FAIL ovf_pre got valid=%0b occ=%0d want 1/0", s.out_valid, occupancy); end
    for (int k = 1; k <= 256; k++) push(13'(k));
    checks++; if (occupancy !== 9'd256 || ovf !== 1'b0)
      begin errors++; $display("FAIL ovf_full got occ=%0d ovf=%0b want 256/0", occupancy, ovf); end
    push(13'd257);
    checks++; if (occupancy !== 9'd256 || ovf !== 1'b1 || drop_cnt !== 8'd1)
      begin errors++; $display("FAIL ovf_hit got occ=%0d ovf=%0b drop=%0d want 256/1/1", occupancy, ovf, drop_cnt); end
    checks++; if (s.out_idx !== 8'd0 || s.ang_out !== 13'h0100)
      begin errors++; $display("FAIL ovf_hold got idx=%0d ang=%h want 0/0100", s.out_idx, s.ang_out); end
    s.out_ready = 1'b1;
    step();
    checks++; if (s.out_idx !== 8'd2 || s.ang_out !== 13'd2 || s.ang_diff !== 13'h1F02 || s.out_first !== 1'b0)
      begin errors++; $display("FAIL ovf_next got idx=%0d ang=%h diff=%h first=%0b want 2/0002/1f02/0", s.out_idx, s.ang_out, s.ang_diff, s.out_first); end
    checks++; if (occupancy !== 9'd255) begin errors++; $display("FAIL ovf_drain got %0d want 255", occupancy); end
    s.out_ready = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (ovf !== 1'b0 || drop_cnt !== 8'd0 || occupancy !== 9'd0 || s.out_valid !== 1'b0)
      begin errors++; $display("FAIL ovf_flush got ovf=%0b drop=%0d occ=%0d valid=%0b want 0/0/0/0", ovf, drop_cnt, occupancy, s.out_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 1; k <= 6; k++) push(13'(k * 16));
    checks++; if (occupancy !== 9'd5) begin errors++; $display("FAIL flush_pre got %0d want 5", occupancy); end
    angle_buf[write_ptr] = 13'h0777;
    write_ptr = write_ptr + 8'd1;
    buf_valid = 1'b1;
    flush = 1'b1;
    step();
    buf_valid = 1'b0;
    flush = 1'b0;
    checks++; if (occupancy !== 9'd0 || s.out_valid !== 1'b0 || ovf !== 1'b0 || drop_cnt !== 8'd0)
      begin errors++; $display("FAIL flush_state got occ=%0d valid=%0b ovf=%0b drop=%0d want 0/0/0/0", occupancy, s.out_valid, ovf, drop_cnt); end
    s.out_ready = 1'b1;
    push(13'h0ABC);
    step();
    checks++; if (s.out_valid !== 1'b1 || s.out_idx !== 8'd7 || s.out_first !== 1'b1 || s.ang_diff !== 13'd0 || s.ang_out !== 13'h0ABC)
      begin errors++; $display("FAIL flush_next got valid=%0b idx=%0d first=%0b diff=%h ang=%h want 1/7/1/0000/0abc", s.out_valid, s.out_idx, s.out_first, s.ang_diff, s.ang_out); end
  endtask

  task automatic test_pointer_wrap();
    do_reset();
    s.out_ready = 1'b1;
    push(13'd0);
    for (int i = 1; i < 300; i++) begin
      push(13'(i * 37));
      checks++; if (s.out_valid !== 1'b1 || s.out_idx !== 8'(i - 1) || s.ang_out !== 13'((i - 1) * 37)
                    || s.ang_diff !== ((i == 1) ? 13'd0 : 13'd37))
        begin errors++; $display("FAIL ptr_wrap_%0d got valid=%0b idx=%0d ang=%h diff=%h want idx=%0d", i - 1, s.out_valid, s.out_idx, s.ang_out, s.ang_diff, (i - 1) % 256); end
    end
    step();
    checks++; if (s.out_idx !== 8'd43 || ovf !== 1'b0 || occupancy !== 9'd0)
      begin errors++; $display("FAIL ptr_wrap_end got idx=%0d ovf=%0b occ=%0d want 43/0/0", s.out_idx, ovf, occupancy); end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    push(13'h0055);
    push(13'h0066);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (s.out_valid !== 1'b0 || occupancy !== 9'd0 || s.ang_out !== 13'd0 || s.out_idx !== 8'd0)
      begin errors++; $display("FAIL async_reset got valid=%0b occ=%0d ang=%h idx=%0d want 0/0/0/0", s.out_valid, occupancy, s.ang_out, s.out_idx); end
    do_reset();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    buf_valid = 1'b0;
    flush = 1'b0;
    write_ptr = 8'd0;
    s.out_ready = 1'b0;
    test_reset();
    test_single_write();
    test_phase_wrap();
    test_backpressure();
    test_overflow();
    test_flush();
    test_pointer_wrap();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/angle_buf_reader.md
# angle_buf_reader

Read-side consumer of the 256-entry angle ring buffer. It tracks how many entries are occupied, using the writer's `buf_valid` pulses, and walks a read pointer behind the writer's `write_ptr`. Entries are streamed out oldest-first on a valid/ready interface, each with a wrapped phase difference against the previously emitted angle. It sits between the angle ring buffer and downstream epsilon/phase-difference logic that cannot accept one sample per cycle.

## Interface
- `DEPTH`, 256: ring entries. Power of two; pointer width is log2(DEPTH) = 8.
- `ANG_W`, 13: angle width, two's-complement, full scale = one turn.
- `clk` in, 1: clock, rising edge.
- `rst` in, 1: reset, asynchronous, active-high.
- `buf_valid` in, 1: writer pulse. The entry at `write_ptr-1` became readable this cycle.
- `write_ptr` in, 8: writer's next write index.
- `angle_buf` in, DEPTH x ANG_W: writer's storage array, read combinationally.
- `flush` in, 1: synchronous discard of all pending entries.
- `out_ready` in, 1: downstream accepts the current output.
- `out_valid` out, 1: output register holds a sample.
- `ang_out` out, ANG_W: emitted angle.
- `ang_diff` out, ANG_W: `ang_out` minus the previous emitted angle, modulo 2^ANG_W.
- `out_first` out, 1: sample is the first since reset/flush; `ang_diff` is 0.
- `out_idx` out, 8: ring index the sample came from.
- `occupancy` out, 9: unread entries, 0..256, excluding the output register.
- `ovf` out, 1: sticky; the writer lapped the reader.
- `drop_cnt` out, 8: saturating count of entries lost to overflow.

## Operation
- State: `rd_ptr`[7:0], `occ`[8:0], output register, `prev_ang`, `first_pend`, `ovf`, `drop_cnt`.
- `load` = `occ`≠0 AND (!`out_valid` OR `out_ready`) AND NOT the overflow case AND NOT `flush`.
- On `load`, the output register captures:
  - `ang_out` ← `angle_buf[rd_ptr]`, `out_idx` ← `rd_ptr`.
  - `ang_diff` ← `first_pend` ? 0 : (`angle_buf[rd_ptr]` − `prev_ang`), truncated to ANG_W bits.
  - `out_first` ← `first_pend`.
  - `prev_ang` ← `angle_buf[rd_ptr]`, `rd_ptr`+1 (wraps 255→0), `first_pend` ← 0.
- Normal occupancy update: `occ` ← `occ` + `buf_valid` − `load`.
- Overflow case (`buf_valid` AND `occ`==256): the entry at `rd_ptr` has already been overwritten.
  - `rd_ptr`+1, `occ` stays 256, `load` is suppressed, `ovf` ← 1, `drop_cnt`+1 (saturates at 255).
- Output handshake: `out_valid` clears on `out_ready` without `load`. Output fields hold stable while `out_valid` AND !`out_ready`.
- `flush` (highest priority after reset):
  - `rd_ptr` ← `write_ptr`, `occ` ← 0, `out_valid` ← 0.
  - `first_pend` ← 1, `ovf` ← 0, `drop_cnt` ← 0.
  - A concurrent `buf_valid` entry is discarded.
- Reset values: `rd_ptr`=0, `occ`=0, `out_valid`=0, `ang_out`/`ang_diff`/`out_idx`=0, `out_first`=0, `prev_ang`=0, `first_pend`=1, `ovf`=0, `drop_cnt`=0.
- Reset and writer reset are asserted together. The invariant `rd_ptr`+`occ` ≡ `write_ptr` (mod 256) holds outside overflow.

## Timing
- All state is registered. `angle_buf` and `write_ptr` are sampled combinationally in the cycle of use.
- Latency: `buf_valid` in cycle N with the block empty and idle gives `occ`=1 in cycle N+1 and `out_valid`=1 in cycle N+2.
- Throughput: 1 sample/cycle while `out_ready`=1 and `occ`>0. No bubble between back-to-back samples.
- `occupancy` reflects the registered `occ`, updated one cycle after the `buf_valid`/`load` that changes it.
- `buf_valid` and `load` in the same cycle leave `occ` unchanged.
- Reset mid-stream: outputs return to reset values asynchronously. Any in-flight sample is lost, with no partial handshake.

## Test plan
- Single write:
  - Stimulus: reset, writer stores 0x0100 at index 0 with `buf_valid` in cycle 5, `out_ready`=1.
  - Required: `out_valid` in cycle 7 with `ang_out`=0x0100, `out_idx`=0, `out_first`=1, `ang_diff`=0; `occupancy` back to 0.
- Phase wrap:
  - Stimulus: emitted angles 0x0FF0 then 0x1010 (13-bit).
  - Required: second sample `ang_diff`=0x0020, `out_first`=0; also 0x1FF0→0x0010 gives `ang_diff`=0x0020.
- Backpressure:
  - Stimulus: 4 writes with `out_ready`=0 for 10 cycles, then `out_ready`=1.
  - Required: first sample held stable; `occupancy`=3 while stalled; indices 0,1,2,3 emitted in consecutive cycles after release.
- Overflow:
  - Stimulus: `out_ready`=0 after one sample is in the output register, then 257 more writes.
  - Required: `occupancy` reaches 256; the 257th write sets `ovf`=1, `drop_cnt`=1 and advances `rd_ptr` by 1. After release, the next `out_idx` is the dropped index + 1.
- Flush with a concurrent write:
  - Stimulus: `flush` and `buf_valid` in the same cycle with `occ`=5.
  - Required: `occupancy`=0, `out_valid`=0, `ovf`=0, `drop_cnt`=0; the next write's sample has `out_first`=1 and `out_idx` equal to the `write_ptr` value at flush.
- Pointer wrap:
  - Stimulus: 300 streamed writes.
  - Required: `out_idx` goes 255→0 seamlessly with no `ovf`.
